mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 16-bit memory port between two requesters: the CPU controller's load/store path (port A) and a DMA/display-refresh engine (port B).
- Serialises one access at a time and handles a fixed-latency synchronous memory.
- Fairness is round-robin on ties, with a burst cap so neither port can starve the other.
- Sits between the CPU/DMA blocks and the memory module.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_re to valid mem_rdata; legal range 1..7.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- a_req  in  1  port A request; held until a_gnt.
- a_we  in  1  port A write (1) / read (0); sampled at grant.
- a_addr  in  16  port A address; sampled at grant.
- a_wdata  in  16  port A write data; sampled at grant.
- a_gnt  out  1  one-cycle pulse: request accepted.
- a_done  out  1  one-cycle pulse: access complete; a_rdata valid this cycle.
- a_rdata  out  16  read data; holds its value until the next A read completes.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as the A ports, for port B.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_re.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, last_owner=B (A wins the first tie), burst_cnt=0.
- States and transitions:
  - IDLE: if any req is high, pick a winner and go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): winner's gnt=1; latch we/addr/wdata into the internal txn register; drive mem_addr/mem_wdata from the latch; mem_we=we or mem_re=~we. Next state is WAIT for a read, DONE for a write.
  - WAIT: wait_cnt counts 1..MEM_LAT; at MEM_LAT, capture mem_rdata into the owner's rdata and go to DONE.
  - DONE (1 cycle): owner's done=1, then IDLE.
- Latency:
  - write: req seen in IDLE -> gnt at +1 -> done at +2.
  - read: gnt at +1 -> done at +MEM_LAT+2.
  - Back-to-back accesses: the next grant comes no earlier than 1 cycle after done (IDLE revisited).
- Arbitration, applied in IDLE only:
  - Single requester wins.
  - Both requesting: the port other than last_owner wins, unless burst_cnt<MAX_BURST and last_owner is still requesting; then last_owner wins.
  - burst_cnt increments when the same owner is re-granted while the other port is requesting; it resets to 0 on an owner change or when the other port is idle.
  - With MAX_BURST=1 this is strict alternation.
- mem_addr/mem_wdata hold their latched values from ISSUE until the next ISSUE; they do not return to 0 between accesses.
- A req still high in DONE is treated as a new request in the following IDLE cycle. A req dropped before gnt is lost without error.
- A req is ignored while busy; gnt never pulses outside ISSUE.
- Reset mid-transaction aborts it immediately: no done pulse, and the memory strobes drop asynchronously.
- wait_cnt is 3 bits; it never wraps because MEM_LAT≤7.
- Never more than one of mem_we/mem_re high; never both gnts; never both dones.

Optional Feature:
- Macro: TINY16_ARB_STATS_EN.
- With the macro: adds outputs a_cnt[15:0], b_cnt[15:0] (completed accesses per port) and stall_cnt[15:0] (cycles any req is high while busy). All counters saturate at 16'hFFFF, reset to 0, and are cleared synchronously by the extra input stats_clr.
- Without the macro: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include (tiny16_bus.vh):
  - state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2, ARB_DONE=2'd3.
  - owner encodings OWN_A=1'b0, OWN_B=1'b1.
  - bus width constant 16.
- One sub-module: arb_pick, a two-way round-robin selector with burst cap. Inputs: reqs, last_owner, burst_cnt. Outputs: winner, next burst_cnt. It is purely combinational; the FSM and datapath stay in mem_arbiter.

Test Plan:
- Reset: rst=0 mid-read (state WAIT) -> all outputs 0 immediately; after release, no done pulse; next a_req read of 16'h0010 completes normally.
- Single write: A write addr 16'h0100, wdata 16'hBEEF -> a_gnt at +1 with mem_we=1, mem_addr=16'h0100, mem_wdata=16'hBEEF; a_done at +2; read back -> a_rdata=16'hBEEF at +MEM_LAT+2.
- Tie at reset: a_req and b_req rise together -> A granted first, B granted at the next IDLE; b_rdata unaffected by A's read.
- Burst cap: MAX_BURST=4, A requests continuously, B held high -> grant sequence A,A,A,A,A,B,… (first A grant plus 4 consecutive re-grants before B wins); B waits ≤5 A transactions.
- Latency sweep: MEM_LAT=1 and MEM_LAT=3 reads -> done exactly 3 and 5 cycles after req sampled; mem_re a single-cycle pulse; busy high throughout.
- With TINY16_ARB_STATS_EN: 3 A reads + 2 B writes -> a_cnt=3, b_cnt=2; stats_clr pulse -> all counters 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and transaction type for the memory arbiter
package mem_arbiter_pkg;

  localparam int BUS_W = 16;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef struct packed {
    logic             we;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signals of the arbiter
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic             a_req, a_we, a_gnt, a_done;
  logic [BUS_W-1:0] a_addr, a_wdata, a_rdata;
  logic             b_req, b_we, b_gnt, b_done;
  logic [BUS_W-1:0] b_addr, b_wdata, b_rdata;
  logic [BUS_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic             mem_we, mem_re, busy;

  // requesters plus the memory model
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  a_gnt, a_done, a_rdata, b_gnt, b_done, b_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    output a_gnt, a_done, a_rdata, b_gnt, b_done, b_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, busy
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - two-way round-robin winner select with burst cap
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic [1:0] i_reqs,
  input  logic       i_last_owner,
  input  logic       i_last_vld,
  input  logic [3:0] i_burst_cnt,
  output logic       o_winner,
  output logic [3:0] o_burst_nxt
);

  localparam logic [3:0] CAP = 4'(MAX_BURST);

  logic w_keep;

  // No owner has been granted since reset, so a tie falls to the non-last port (A).
  assign w_keep = i_last_vld && i_reqs[i_last_owner] && (i_burst_cnt < CAP);

  always_comb begin
    o_winner    = OWN_A;
    o_burst_nxt = 4'd0;
    case (i_reqs)
      2'b01:   o_winner = OWN_A;
      2'b10:   o_winner = OWN_B;
      2'b11:   o_winner = w_keep ? i_last_owner : ~i_last_owner;
      default: o_winner = OWN_A;
    endcase
    if (i_last_vld && (o_winner == i_last_owner) && i_reqs[~o_winner])
      o_burst_nxt = i_burst_cnt + 4'd1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one 16-bit memory port between requesters A and B
// Optional access/stall statistics counters: TINY16_ARB_STATS_EN
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef TINY16_ARB_STATS_EN
  input  logic             stats_clr,
  output logic [BUS_W-1:0] a_cnt,
  output logic [BUS_W-1:0] b_cnt,
  output logic [BUS_W-1:0] stall_cnt,
`endif
  mem_arbiter_if.slave     bus
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  logic [1:0]       r_state;
  logic             r_owner, r_last_owner, r_last_vld;
  logic [3:0]       r_burst_cnt;
  logic [2:0]       r_wait_cnt;
  txn_t             r_txn;
  logic             r_a_gnt, r_b_gnt, r_a_done, r_b_done, r_mem_we, r_mem_re;
  logic [BUS_W-1:0] r_a_rdata, r_b_rdata;

  logic       w_winner, w_busy;
  logic [1:0] w_reqs;
  logic [3:0] w_burst_nxt;

  assign w_reqs = {bus.b_req, bus.a_req};
  assign w_busy = (r_state != ARB_IDLE);

  arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .i_reqs      (w_reqs),
    .i_last_owner(r_last_owner),
    .i_last_vld  (r_last_vld),
    .i_burst_cnt (r_burst_cnt),
    .o_winner    (w_winner),
    .o_burst_nxt (w_burst_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_A;
      r_last_owner <= OWN_B;
      r_last_vld   <= 1'b0;
      r_burst_cnt  <= 4'd0;
      r_wait_cnt   <= 3'd0;
      r_txn        <= '0;
      r_a_gnt      <= 1'b0;
      r_b_gnt      <= 1'b0;
      r_a_done     <= 1'b0;
      r_b_done     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (|w_reqs) begin
            r_state      <= ARB_ISSUE;
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_last_vld   <= 1'b1;
            r_burst_cnt  <= w_burst_nxt;
            if (w_winner == OWN_B) begin
              r_txn    <= {bus.b_we, bus.b_addr, bus.b_wdata};
              r_b_gnt  <= 1'b1;
              r_mem_we <= bus.b_we;
              r_mem_re <= ~bus.b_we;
            end else begin
              r_txn    <= {bus.a_we, bus.a_addr, bus.a_wdata};
              r_a_gnt  <= 1'b1;
              r_mem_we <= bus.a_we;
              r_mem_re <= ~bus.a_we;
            end
          end
        end
        ARB_ISSUE: begin
          r_wait_cnt <= 3'd1;
          if (r_txn.we) begin
            r_state  <= ARB_DONE;
            r_a_done <= (r_owner == OWN_A);
            r_b_done <= (r_owner == OWN_B);
          end else begin
            r_state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (r_wait_cnt == LAT) begin
            r_state  <= ARB_DONE;
            r_a_done <= (r_owner == OWN_A);
            r_b_done <= (r_owner == OWN_B);
            if (r_owner == OWN_B) r_b_rdata <= bus.mem_rdata;
            else                  r_a_rdata <= bus.mem_rdata;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.a_gnt     = r_a_gnt;
  assign bus.b_gnt     = r_b_gnt;
  assign bus.a_done    = r_a_done;
  assign bus.b_done    = r_b_done;
  assign bus.a_rdata   = r_a_rdata;
  assign bus.b_rdata   = r_b_rdata;
  assign bus.mem_addr  = r_txn.addr;
  assign bus.mem_wdata = r_txn.wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.busy      = w_busy;

`ifdef TINY16_ARB_STATS_EN
  logic [BUS_W-1:0] r_a_cnt, r_b_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_cnt     <= '0;
      r_b_cnt     <= '0;
      r_stall_cnt <= '0;
    end else if (stats_clr) begin
      r_a_cnt     <= '0;
      r_b_cnt     <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_a_done && (r_a_cnt != 16'hFFFF)) r_a_cnt <= r_a_cnt + 16'd1;
      if (r_b_done && (r_b_cnt != 16'hFFFF)) r_b_cnt <= r_b_cnt + 16'd1;
      if ((|w_reqs) && w_busy && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign a_cnt     = r_a_cnt;
  assign b_cnt     = r_b_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if bus1();
  mem_arbiter_if bus3();

`ifdef TINY16_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] a_cnt1, b_cnt1, stall1, a_cnt3, b_cnt3, stall3;
`endif

  mem_arbiter #(.MEM_LAT(1), .MAX_BURST(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
`ifdef TINY16_ARB_STATS_EN
    .stats_clr(stats_clr),
    .a_cnt    (a_cnt1),
    .b_cnt    (b_cnt1),
    .stall_cnt(stall1),
`endif
    .bus      (bus1)
  );

  mem_arbiter #(.MEM_LAT(3), .MAX_BURST(4)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
`ifdef TINY16_ARB_STATS_EN
    .stats_clr(stats_clr),
    .a_cnt    (a_cnt3),
    .b_cnt    (b_cnt3),
    .stall_cnt(stall3),
`endif
    .bus      (bus3)
  );

  always #5 clk = ~clk;

  // Memory models: data appears exactly MEM_LAT cycles after the read strobe, DEAD otherwise.
  logic [15:0] mem1 [0:255];
  logic [15:0] pipe1;
  logic [15:0] pipe3 [0:2];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 16'(i) ^ 16'h5A5A;
    end else if (bus1.mem_we) begin
      mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end
    pipe1 <= bus1.mem_re ? mem1[bus1.mem_addr[7:0]] : 16'hDEAD;
  end
  assign bus1.mem_rdata = pipe1;

  always @(posedge clk) begin
    pipe3[0] <= bus3.mem_re ? (bus3.mem_addr ^ 16'h5A5A) : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.mem_rdata = pipe3[2];

  logic        g_we, g_re;
  logic [15:0] g_addr, g_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic access(input bit p, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int gnt_cyc,
                        output int done_cyc, output logic [15:0] rdata);
    int cyc;
    cyc = 0; gnt_cyc = -1; done_cyc = -1; rdata = '0;
    if (p) begin
      bus1.b_req = 1'b1; bus1.b_we = we; bus1.b_addr = addr; bus1.b_wdata = wdata;
    end else begin
      bus1.a_req = 1'b1; bus1.a_we = we; bus1.a_addr = addr; bus1.a_wdata = wdata;
    end
    while (done_cyc < 0 && cyc < 20) begin
      tick();
      cyc++;
      if ((p ? bus1.b_gnt : bus1.a_gnt) && gnt_cyc < 0) begin
        gnt_cyc = cyc;
        g_we = bus1.mem_we; g_re = bus1.mem_re;
        g_addr = bus1.mem_addr; g_wdata = bus1.mem_wdata;
        if (p) bus1.b_req = 1'b0; else bus1.a_req = 1'b0;
      end
      if (p ? bus1.b_done : bus1.a_done) begin
        done_cyc = cyc;
        rdata = p ? bus1.b_rdata : bus1.a_rdata;
      end
    end
    bus1.a_req = 1'b0;
    bus1.b_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gc, dc, cyc, ndone, ng, viol, ag, bg, re_cnt, busy_cnt;
    logic [15:0] rd, a_rd, b_rd;
    logic [6:0]  seq;

    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = '0; bus1.a_wdata = '0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = '0; bus1.b_wdata = '0;
    bus3.a_req = 0; bus3.a_we = 0; bus3.a_addr = '0; bus3.a_wdata = '0;
    bus3.b_req = 0; bus3.b_we = 0; bus3.b_addr = '0; bus3.b_wdata = '0;
    repeat (3) tick();
    chk("rst_busy",   bus1.busy,     0);
    chk("rst_gnt",    {bus1.a_gnt, bus1.b_gnt, bus1.a_done, bus1.b_done}, 0);
    chk("rst_strobe", {bus1.mem_we, bus1.mem_re}, 0);
    chk("rst_addr",   bus1.mem_addr, 0);
    chk("rst_rdata",  {bus1.a_rdata, bus1.b_rdata}, 0);
    rst = 1'b1;
    tick();

    // Reset while a read is in WAIT
    bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 16'h0020;
    tick();
    chk("abort_gnt", bus1.a_gnt, 1);
    chk("abort_re",  bus1.mem_re, 1);
    bus1.a_req = 1'b0;
    tick();
    chk("abort_busy_wait", bus1.busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_busy_clr", bus1.busy, 0);
    chk("abort_addr_clr", bus1.mem_addr, 0);
    chk("abort_strobes",  {bus1.mem_we, bus1.mem_re, bus1.a_gnt, bus1.a_done}, 0);
    repeat (2) tick();
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ndone += int'(bus1.a_done | bus1.b_done);
    end
    chk("abort_no_done", ndone, 0);
    access(1'b0, 1'b0, 16'h0010, 16'h0000, gc, dc, rd);
    chk("post_rst_gnt",   gc, 1);
    chk("post_rst_done",  dc, 3);
    chk("post_rst_rdata", rd, 16'h5A4A);

    // Single write then read back
    access(1'b0, 1'b1, 16'h0100, 16'hBEEF, gc, dc, rd);
    chk("wr_gnt",   gc, 1);
    chk("wr_done",  dc, 2);
    chk("wr_strobe", {g_we, g_re}, 2'b10);
    chk("wr_addr",  g_addr, 16'h0100);
    chk("wr_wdata", g_wdata, 16'hBEEF);
    access(1'b0, 1'b0, 16'h0100, 16'h0000, gc, dc, rd);
    chk("rd_strobe", {g_we, g_re}, 2'b01);
    chk("rd_done",   dc, 3);
    chk("rd_rdata",  rd, 16'hBEEF);
    chk("addr_hold", bus1.mem_addr, 16'h0100);

    // Tie straight after reset: A first, B at the next IDLE
    rst_pulse();
    bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 16'h0030;
    bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 16'h0040; bus1.b_wdata = 16'h1234;
    ag = -1; bg = -1; a_rd = '0; b_rd = 16'hFFFF; cyc = 0;
    while (cyc < 20 && !bus1.b_done) begin
      tick();
      cyc++;
      if (bus1.a_gnt) begin ag = cyc; bus1.a_req = 1'b0; end
      if (bus1.b_gnt) begin bg = cyc; bus1.b_req = 1'b0; end
      if (bus1.a_done) begin a_rd = bus1.a_rdata; b_rd = bus1.b_rdata; end
    end
    bus1.a_req = 1'b0; bus1.b_req = 1'b0;
    tick();
    chk("tie_a_gnt",   ag, 1);
    chk("tie_b_gnt",   bg, 5);
    chk("tie_a_rdata", a_rd, 16'h5A6A);
    chk("tie_b_rdata", b_rd, 16'h0000);

    // Burst cap with both ports requesting writes continuously
    rst_pulse();
    bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 16'h0050; bus1.a_wdata = 16'h1111;
    bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 16'h0060; bus1.b_wdata = 16'h2222;
    seq = '0; ng = 0; viol = 0; cyc = 0;
    while (ng < 7 && cyc < 60) begin
      tick();
      cyc++;
      if (bus1.a_gnt && bus1.b_gnt) viol++;
      if (bus1.a_done && bus1.b_done) viol++;
      if (bus1.mem_we && bus1.mem_re) viol++;
      if (bus1.a_gnt) begin seq[ng] = 1'b0; ng++; end
      else if (bus1.b_gnt) begin seq[ng] = 1'b1; ng++; end
    end
    bus1.a_req = 1'b0; bus1.b_req = 1'b0;
    repeat (3) tick();
    chk("burst_count", ng, 7);
    chk("burst_seq",   seq, 7'b1100000);
    chk("burst_excl",  viol, 0);

    // Read latency with MEM_LAT=3
    bus3.a_req = 1'b1; bus3.a_we = 1'b0; bus3.a_addr = 16'h0077;
    cyc = 0; dc = -1; re_cnt = 0; busy_cnt = 0; rd = '0;
    while (dc < 0 && cyc < 20) begin
      tick();
      cyc++;
      if (bus3.a_gnt) bus3.a_req = 1'b0;
      re_cnt   += int'(bus3.mem_re);
      busy_cnt += int'(bus3.busy);
      if (bus3.a_done) begin dc = cyc; rd = bus3.a_rdata; end
    end
    bus3.a_req = 1'b0;
    chk("lat3_done",  dc, 5);
    chk("lat3_re",    re_cnt, 1);
    chk("lat3_busy",  busy_cnt, 5);
    chk("lat3_rdata", rd, 16'h5A2D);
    tick();
    chk("lat3_idle",  bus3.busy, 0);

`ifdef TINY16_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) access(1'b0, 1'b0, 16'(i), 16'h0000, gc, dc, rd);
    for (int i = 0; i < 2; i++) access(1'b1, 1'b1, 16'(i + 8), 16'hCAFE, gc, dc, rd);
    chk("stats_a", a_cnt1, 3);
    chk("stats_b", b_cnt1, 2);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("stats_clr", {a_cnt1, b_cnt1}, 0);
    chk("stats_clr_stall", stall1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
